// File: rtl/seqdet_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seqdet_pkg;

    // Controller states: FILLING while the history window is partial, ARMED once it is full.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } seqdet_state_e;

    localparam int unsigned DEFAULT_LEN     = 3;
    localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 3'b101;
    localparam int unsigned DEFAULT_FILL_W  = $clog2(DEFAULT_LEN + 1);

    // Width of a fill counter that must represent 0..len inclusive.
    function automatic int unsigned fill_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sequence_detector_n_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc          : count up by one unless already at all-ones
//   clr          : clear to zero; wins over inc
//   count        : current value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sequence_detector_n.sv
// Run-time programmable serial pattern detector (Moore output).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : sample w this cycle; otherwise detector state holds
//   w            : serial data bit
//   load         : capture pattern_in and flush history (w ignored)
//   pattern_in   : new pattern, bit LEN-1 is the first-received bit
//   overlap      : 1 keeps history after a match, 0 flushes it
//   count_clear  : synchronous clear of match_count
//   z            : high for the cycle after a matching sample
//   match_count  : saturating number of matches
//   fill         : number of valid history bits, 0..LEN
module sequence_detector_n
    import seqdet_pkg::*;
#(
    parameter int unsigned     LEN         = 3,
    parameter int unsigned     CNT_W       = 8,
    parameter logic [LEN-1:0]  RST_PATTERN = LEN'(DEFAULT_PATTERN)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       w,
    input  logic                       load,
    input  logic [LEN-1:0]             pattern_in,
    input  logic                       overlap,
    input  logic                       count_clear,
    output logic                       z,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(LEN+1)-1:0]   fill
);

    localparam int unsigned FILL_W = fill_width(LEN);

    seqdet_state_e       state;
    seqdet_state_e       state_next;
    logic [LEN-1:0]      history;
    logic [LEN-1:0]      history_next;
    logic [LEN-1:0]      history_shift;
    logic [LEN-1:0]      pattern;
    logic [LEN-1:0]      pattern_next;
    logic [FILL_W-1:0]   fill_next;
    logic                full_after;
    logic                match_c;
    logic                z_next;

    // State, history, pattern and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FILLING;
            history <= '0;
            pattern <= RST_PATTERN;
            fill    <= '0;
            z       <= 1'b0;
        end else begin
            state   <= state_next;
            history <= history_next;
            pattern <= pattern_next;
            fill    <= fill_next;
            z       <= z_next;
        end
    end

    // Next-state logic: load beats enable; an idle cycle holds everything but drops z.
    always_comb begin
        state_next    = state;
        history_next  = history;
        pattern_next  = pattern;
        fill_next     = fill;
        z_next        = 1'b0;
        match_c       = 1'b0;
        history_shift = {history[LEN-2:0], w};
        // The window is full after this sample if already armed or one bit short.
        full_after    = (state == ARMED) || (fill == FILL_W'(LEN - 1));

        if (load) begin
            pattern_next = pattern_in;
            history_next = '0;
            fill_next    = '0;
            state_next   = FILLING;
        end else if (enable) begin
            match_c = full_after && (history_shift == pattern);
            z_next  = match_c;
            if (match_c && !overlap) begin
                history_next = '0;
                fill_next    = '0;
                state_next   = FILLING;
            end else begin
                history_next = history_shift;
                fill_next    = full_after ? FILL_W'(LEN) : fill + FILL_W'(1);
                state_next   = full_after ? ARMED : FILLING;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match_c),
        .clr   (count_clear),
        .count (match_count)
    );

endmodule

// File: tb/tb_sequence_detector_n.sv
// Scoreboard bench: the driver pushes model-predicted outputs, a monitor pops and compares.
module tb_sequence_detector_n;

    localparam int LEN   = 3;
    localparam int CNT_W = 2;
    localparam int RST_PAT = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             w;
    logic             load;
    logic [LEN-1:0]   pattern_in;
    logic             overlap;
    logic             count_clear;
    logic             z;
    logic [CNT_W-1:0] match_count;
    logic [$clog2(LEN+1)-1:0] fill;

    sequence_detector_n #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .w           (w),
        .load        (load),
        .pattern_in  (pattern_in),
        .overlap     (overlap),
        .count_clear (count_clear),
        .z           (z),
        .match_count (match_count),
        .fill        (fill)
    );

    typedef struct {
        bit z;
        int cnt;
        int fill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the history is a queue of received bits, oldest first.
    bit   m_hist[$];
    int   m_pat = RST_PAT;
    int   m_cnt = 0;
    bit   m_z   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int hist_value(input bit h[$]);
        int v = 0;
        foreach (h[i]) v = v * 2 + int'(h[i]);
        return v;
    endfunction

    // Apply one cycle of stimulus and predict what the DUT shows after the next edge.
    task automatic drive(input bit r, input bit ld, input bit en, input bit wv,
                         input bit ov, input bit cc, input int pin);
        bit   m;
        exp_t e;
        @(negedge clock);
        reset       = r;
        load        = ld;
        enable      = en;
        w           = wv;
        overlap     = ov;
        count_clear = cc;
        pattern_in  = LEN'(pin);
        m = 0;
        if (r) begin
            m_hist.delete();
            m_pat = RST_PAT;
            m_cnt = 0;
            m_z   = 0;
        end else begin
            if (ld) begin
                m_pat = pin;
                m_hist.delete();
                m_z = 0;
            end else if (en) begin
                m_hist.push_back(wv);
                if (m_hist.size() > LEN) void'(m_hist.pop_front());
                m = (m_hist.size() == LEN) && (hist_value(m_hist) == m_pat);
                m_z = m;
                if (m && !ov) m_hist.delete();
            end else begin
                m_z = 0;
            end
            if (cc) m_cnt = 0;
            else if (m && m_cnt < CNT_MAX) m_cnt++;
        end
        e.z = m_z;
        e.cnt = m_cnt;
        e.fill = m_hist.size();
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit wv, input bit ov);
        drive(0, 0, 1, wv, ov, 0, 0);
    endtask

    // Monitor: compare after every active edge that has a pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (z !== e.z) begin
                    failures++;
                    $display("FAIL z at %0t: got %b want %b", $time, z, e.z);
                end
                checks++;
                if (int'(match_count) != e.cnt) begin
                    failures++;
                    $display("FAIL match_count at %0t: got %0d want %0d", $time, match_count, e.cnt);
                end
                checks++;
                if (int'(fill) != e.fill) begin
                    failures++;
                    $display("FAIL fill at %0t: got %0d want %0d", $time, fill, e.fill);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; w = 1'b0;
        overlap = 1'b0; count_clear = 1'b0; pattern_in = '0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // 10101 with overlap: two matches.
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

        // Same stream without overlap: one match.
        drive(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);

        // Load 110 with a coincident enabled 1 that must be dropped.
        drive(0, 1, 1, 1, 0, 0, 6);
        bit_in(1, 0); bit_in(1, 0); bit_in(0, 0);

        // Enable gap in the middle of 101.
        drive(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1);
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        bit_in(0, 1); bit_in(1, 1);

        // Pattern 111, overlap: back-to-back matches and counter saturation.
        drive(0, 1, 0, 0, 1, 1, 7);
        for (int i = 0; i < 6; i++) bit_in(1, 1);
        drive(0, 0, 1, 1, 1, 1, 0);
        bit_in(1, 1);

        // Reset mid-stream, then the reset pattern 101 must still be recognised.
        bit_in(1, 1); bit_in(0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 7)));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_detector_n.md
Name: sequence_detector_n

Overview:
Parametrised, run-time programmable serial pattern detector that generalises the team's fixed 3-bit "101" Moore detector. It samples one serial bit `w` per enabled clock and compares the last LEN bits against a loadable pattern register. It raises a registered Moore match flag, optionally allows overlapping matches, and keeps a saturating match counter. It sits on serial input paths (switch/keypad streams, protocol sync-word detection) and is driven directly from board-level inputs.

Parameters:
LEN, 3, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter; legal range 1..16.
RST_PATTERN, 3'b101 (LEN'b…), pattern value loaded at reset; width LEN.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  when 1, `w` is sampled this cycle; when 0, all detector state holds.
w  input  1  serial data bit.
load  input  1  when 1, capture `pattern_in` into the pattern register and flush the history.
pattern_in  input  LEN  new pattern; bit LEN-1 is the oldest (first-received) bit.
overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after each match.
count_clear  input  1  synchronous clear of `match_count`.
z  output  1  Moore match flag: 1 for exactly the cycle after a matching sample.
match_count  output  CNT_W  number of matches seen, saturating.
fill  output  $clog2(LEN+1)  number of valid history bits, 0..LEN.

Behaviour:
- One clock; synchronous, active-high reset (`reset`). All state updates occur on the rising edge of `clock`.
- Reset values:
  - history = 0, fill = 0, z = 0, match_count = 0.
  - pattern register = RST_PATTERN.
- Priority each edge: reset > load > enable.
- Load:
  - pattern ← pattern_in; history ← 0; fill ← 0; z ← 0.
  - `w` is discarded that cycle even if enable = 1.
  - match_count is unaffected.
- Enabled sample (enable = 1, no load):
  - history ← {history[LEN-2:0], w}.
  - fill ← min(fill+1, LEN).
  - Match condition uses the post-shift window: (fill_next == LEN) && (history_next == pattern).
  - On match: z ← 1 the next cycle, so output latency is 1 clock after the sampled bit.
  - On match with overlap = 0: history ← 0 and fill ← 0 instead of the shifted values.
  - On match with overlap = 1: the shifted history is retained, so a later match can share bits.
  - If no match that cycle: z ← 0.
- enable = 0: history, fill and pattern hold; z ← 0, so the flag is never stretched.
- overlap is sampled on the cycle of the match and may change at any time.
- match_count:
  - Increments on each match; holds at 2^CNT_W−1 (no wrap).
  - count_clear takes priority over increment: a match in the same cycle gives count = 0.
- Back-to-back matches (e.g. pattern all-ones with overlap = 1) keep z high on consecutive cycles.
- Reset asserted mid-stream drops any partial match; no match is ever reported across a reset or a load.
- Internal state: a 2-state controller.
  - FILLING (fill < LEN): z never set.
  - ARMED (fill == LEN).
  - FILLING→ARMED when fill reaches LEN.
  - ARMED→FILLING on load, reset, or a non-overlap match.

Decomposition:
- Shared package `seqdet_pkg`:
  - state enum {FILLING, ARMED}.
  - default pattern constant.
  - localparam FILL_W = $clog2(LEN+1).
- One natural sub-module, `sat_counter` (parameter W; inputs inc, clr; output count): the saturating counter, reusable elsewhere.
- History shift register, compare and controller stay in `sequence_detector_n`.

Test Plan:
- LEN=3, default pattern 101, overlap=1, enable=1, stream w=1,0,1,0,1 → z=1 one cycle after bit 3 and one cycle after bit 5; match_count=2.
- Same stream with overlap=0 → z pulses only after bit 3; bits 4–5 refill the history, so there is no second match; match_count=1.
- load with pattern_in=3'b110 and enable=1, w=1 in the same cycle → that bit is ignored and fill=0; then stream 1,1,0 → z=1 after the third bit.
- Enable gaps: stream 1,(enable=0 for 3 cycles),0,1 → match after the last bit; z=0 throughout the gap.
- CNT_W=2, pattern 111, overlap=1, six 1s → z high for 4 consecutive cycles; match_count saturates at 3; count_clear coincident with a match → 0.
- reset asserted after inputs 1,0 then stream 1 → no match; fill=1; z=0; pattern=RST_PATTERN.
